// File: rtl/mmio_arb_pkg.sv
// Shared types and default widths for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

    localparam int DEF_ADDR_W = 21;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner selection with a lock-ownership latch and a last-grant pointer.
// Build option: ARB_FIXED_PRIO_EN makes m0 always win ties and removes the
// round-robin pointer; lock behaviour is identical in both builds.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       arb_en,
    input  logic       ack_cycle,
    input  logic       owner,
    output logic       win_valid,
    output logic       win_idx
);

    logic       lock_held_reg;
    logic       lock_held_next;
    logic       owner_locked;
    logic [1:0] eligible;

    // The lock only keeps holding while the owner continues to assert it.
    assign owner_locked = lock_held_reg && lock[owner];

    // A locked owner is the only eligible requester, even with its req low.
    always_comb begin
        eligible = req;
        if (owner_locked) begin
            eligible = req & (owner ? 2'b10 : 2'b01);
        end
    end

    assign win_valid = |eligible;

    // Lock is sampled in the owner's ACK cycle and dropped in IDLE once released.
    always_comb begin
        lock_held_next = lock_held_reg;
        if (ack_cycle) begin
            lock_held_next = lock[owner];
        end else if (arb_en && !lock[owner]) begin
            lock_held_next = 1'b0;
        end
    end

    // Lock-ownership register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_held_reg <= 1'b0;
        end else begin
            lock_held_reg <= lock_held_next;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // m0 has absolute priority whenever it is eligible.
    always_comb begin
        win_idx = !eligible[0] && eligible[1];
    end
`else
    logic last_reg;

    // On a tie the requester not granted last wins.
    always_comb begin
        if (&eligible) begin
            win_idx = ~last_reg;
        end else begin
            win_idx = eligible[1];
        end
    end

    // Last-grant pointer; resets to 1 so m0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_reg <= 1'b1;
        end else if (arb_en && win_valid) begin
            last_reg <= win_idx;
        end
    end
`endif

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for a shared FPro-style MMIO bus: IDLE arbitrates and
// registers the command, ISSUE strobes the bus for one cycle, ACK returns data.
// Build option: ARB_FIXED_PRIO_EN (fixed m0 priority, see rr_arb2).
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              grant,
    output logic              busy
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic              grant_reg;
    logic              cmd_wr_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_wr_data_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              win_valid;
    logic              win_idx;
    logic              in_issue;
    logic              in_ack;

    assign in_issue = (state_reg == ISSUE);
    assign in_ack   = (state_reg == ACK);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({m1_req, m0_req}),
        .lock      ({m1_lock, m0_lock}),
        .arb_en    (state_reg == IDLE),
        .ack_cycle (in_ack),
        .owner     (grant_reg),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fixed three-step sequence once a winner is chosen.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_valid) state_next = ISSUE;
            ISSUE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command is frozen at grant so requester changes cannot disturb the bus cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_reg       <= 1'b0;
            cmd_wr_reg      <= 1'b0;
            cmd_addr_reg    <= '0;
            cmd_wr_data_reg <= '0;
            rd_data_reg     <= '0;
        end else if (state_reg == IDLE && win_valid) begin
            grant_reg       <= win_idx;
            cmd_wr_reg      <= win_idx ? m1_wr      : m0_wr;
            cmd_addr_reg    <= win_idx ? m1_addr    : m0_addr;
            cmd_wr_data_reg <= win_idx ? m1_wr_data : m0_wr_data;
        end else if (in_issue) begin
            rd_data_reg <= cmd_wr_reg ? '0 : mmio_rd_data;
        end
    end

    assign mmio_cs      = in_issue;
    assign mmio_wr      = in_issue && cmd_wr_reg;
    assign mmio_rd      = in_issue && !cmd_wr_reg;
    assign mmio_addr    = in_issue ? cmd_addr_reg : '0;
    assign mmio_wr_data = in_issue ? cmd_wr_data_reg : '0;

    assign m0_ack     = in_ack && !grant_reg;
    assign m1_ack     = in_ack && grant_reg;
    assign m0_rd_data = in_ack ? rd_data_reg : '0;
    assign m1_rd_data = in_ack ? rd_data_reg : '0;

    assign grant = grant_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: read, write, contention, lock,
// reset mid-transaction and command-change scenarios.
module tb_mmio_bus_arbiter;

    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m1_req, m0_wr, m1_wr, m0_lock, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          mmio_cs, mmio_wr, mmio_rd;
    logic [AW-1:0] mmio_addr;
    logic [DW-1:0] mmio_wr_data;
    logic [DW-1:0] mmio_rd_data;
    logic          grant, busy;

    int passed = 0;
    int total  = 0;
    logic [3:0] exp_order;

    always #5 clk = ~clk;

    mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data),
        .grant(grant), .busy(busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
        mmio_rd_data = '0;
        tick(); tick();

        // Reset state
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_cs", mmio_cs, 0);
        check("rst_acks", {m0_ack, m1_ack}, 0);
        check("rst_rdata", m0_rd_data | m1_rd_data, 0);
        reset = 1'b1;
        tick();

        // Single read by m0
        m0_req = 1; m0_wr = 0; m0_addr = 21'h000C0; mmio_rd_data = 32'hDEADBEEF;
        tick();
        check("rd_strobe", {mmio_cs, mmio_rd, mmio_wr}, 3'b110);
        check("rd_addr", mmio_addr, 21'h000C0);
        check("rd_grant", grant, 0);
        check("rd_busy", busy, 1);
        check("rd_no_early_ack", m0_ack, 0);
        tick();
        check("rd_ack", {m0_ack, m1_ack}, 2'b10);
        check("rd_data", m0_rd_data, 32'hDEADBEEF);
        check("rd_cs_off", mmio_cs, 0);
        m0_req = 0;
        tick();
        check("rd_idle", {busy, m0_ack}, 0);

        // Single write by m1
        m1_req = 1; m1_wr = 1; m1_addr = 21'h00080; m1_wr_data = 32'h55;
        tick();
        check("wr_strobe", {mmio_cs, mmio_rd, mmio_wr}, 3'b101);
        check("wr_addr", mmio_addr, 21'h00080);
        check("wr_data_bus", mmio_wr_data, 32'h55);
        check("wr_grant", grant, 1);
        tick();
        check("wr_ack", {m0_ack, m1_ack}, 2'b01);
        check("wr_rdata_zero", m1_rd_data, 0);
        m1_req = 0; m1_wr = 0;
        tick();

        // Contention from reset: both requesters held high
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m0_req = 1; m1_req = 1; m0_addr = 21'h10; m1_addr = 21'h20;
        mmio_rd_data = 32'h1234;
`ifdef ARB_FIXED_PRIO_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("cont_grant%0d", i), grant, exp_order[i]);
            check($sformatf("cont_addr%0d", i), mmio_addr, exp_order[i] ? 21'h20 : 21'h10);
            tick();
            check($sformatf("cont_ack%0d", i), {m0_ack, m1_ack}, exp_order[i] ? 2'b01 : 2'b10);
            if (i == 3) begin
                m0_req = 0; m1_req = 0;
            end
            tick();
        end

        // Lock: m1 holds ownership for three writes while m0 waits
        m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = 21'h00300; m1_wr_data = 32'h77;
        tick();
        check("lock_grant0", grant, 1);
        m0_req = 1; m0_wr = 0; m0_addr = 21'h00400;
        tick();
        check("lock_ack0", {m0_ack, m1_ack}, 2'b01);
        for (int w = 1; w < 3; w++) begin
            tick();
            tick();
            check($sformatf("lock_grant%0d", w), grant, 1);
            check($sformatf("lock_wr%0d", w), mmio_wr, 1);
            tick();
            check($sformatf("lock_ack%0d", w), {m0_ack, m1_ack}, 2'b01);
            if (w == 2) m1_req = 0;
        end
        tick();
        check("lock_wait1", busy, 0);
        tick();
        check("lock_wait2", {busy, grant}, 2'b01);
        m1_lock = 0;
        tick();
        check("lock_release_grant", {busy, grant}, 2'b10);
        check("lock_release_addr", mmio_addr, 21'h00400);
        tick();
        check("lock_release_ack", {m0_ack, m1_ack}, 2'b10);
        m0_req = 0;
        tick();

        // Command change during ISSUE
        m0_req = 1; m0_wr = 0; m0_addr = 21'h00100; mmio_rd_data = 32'hCAFEF00D;
        tick();
        check("chg_addr_before", mmio_addr, 21'h00100);
        m0_addr = 21'h1FFFF; m0_wr = 1;
        #1;
        check("chg_addr_after", mmio_addr, 21'h00100);
        check("chg_strobe", {mmio_rd, mmio_wr}, 2'b10);
        tick();
        check("chg_rdata", m0_rd_data, 32'hCAFEF00D);
        m0_req = 0; m0_wr = 0;
        tick();

        // Reset asserted during ISSUE
        m1_req = 1; m1_wr = 1; m1_addr = 21'h00040; m1_wr_data = 32'hAA;
        tick();
        check("rmid_cs", mmio_cs, 1);
        reset = 1'b0;
        m0_req = 1;
        #1;
        check("rmid_strobes", {mmio_cs, mmio_wr, mmio_rd}, 0);
        check("rmid_busy_grant", {busy, grant}, 0);
        check("rmid_bus", {mmio_addr, mmio_wr_data}, 0);
        check("rmid_acks", {m0_ack, m1_ack}, 0);
        tick();
        check("rmid_no_ack", {m0_ack, m1_ack, busy}, 0);
        reset = 1'b1;
        tick();
        check("rmid_m0_first", {busy, grant}, 2'b10);
        tick();
        check("rmid_m0_ack", {m0_ack, m1_ack}, 2'b10);
        m0_req = 0;
        tick();
        tick();
        check("rmid_m1_reissue", {grant, mmio_wr}, 2'b11);
        check("rmid_m1_data", mmio_wr_data, 32'hAA);
        tick();
        check("rmid_m1_ack", {m0_ack, m1_ack}, 2'b01);
        m1_req = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mmio_bus_arbiter.md
MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 21: width of the MMIO address.
REQ-002 Parameter DATA_W, default 32: width of the MMIO data.
REQ-003 The block SHALL have these ports, with clock and reset first:
- clk  input  1  single clock; all logic SHALL use its rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req, m1_req  input  1  request valid; SHALL be held high with a stable command until the matching ack.
- m0_wr, m1_wr  input  1  1 = write, 0 = read.
- m0_lock, m1_lock  input  1  keeps ownership across transactions.
- m0_addr, m1_addr  input  ADDR_W  target address.
- m0_wr_data, m1_wr_data  input  DATA_W  write data.
- m0_ack, m1_ack  output  1  one-cycle completion pulse.
- m0_rd_data, m1_rd_data  output  DATA_W  read result; valid only in the ack cycle.
- mmio_cs, mmio_wr, mmio_rd  output  1  shared FPro bus strobes.
- mmio_addr  output  ADDR_W  bus address.
- mmio_wr_data  output  DATA_W  bus write data.
- mmio_rd_data  input  DATA_W  bus read data; combinational from the slot in the strobe cycle.
- grant  output  1  index of the current or last owner.
- busy  output  1  high in the ISSUE and ACK states.

Function
REQ-004 The FSM SHALL have three states: IDLE, ISSUE and ACK.
REQ-005 In IDLE, when any eligible req is high, the FSM SHALL register the winner's wr, addr and wr_data, update grant, and move to ISSUE.
REQ-006 In ISSUE, the FSM SHALL assert mmio_cs for exactly one cycle, plus mmio_wr if wr=1 or mmio_rd if wr=0, and drive the registered addr and wr_data.
- For a read, it SHALL capture mmio_rd_data at the end of that cycle.
- It SHALL then move to ACK.
REQ-007 In ACK, the FSM SHALL pulse the owner's ack for one cycle and drive the captured data on both rd_data outputs.
- For a write, rd_data SHALL be 0.
- The FSM SHALL then return to IDLE.
REQ-008 Latency SHALL be: req sampled in cycle n, bus strobe in cycle n+1, ack in cycle n+2, and the next arbitration no earlier than cycle n+3.
REQ-009 A req that is still high in the cycle after its ack SHALL be treated as a new request.
REQ-010 The non-owner's ack SHALL be 0 in every cycle, and all bus strobes SHALL be 0 outside ISSUE.
REQ-011 Round-robin: when both reqs are high in IDLE, the requester not granted last SHALL win.
REQ-012 Lock: if the last owner's lock was high in its ACK cycle and is still high in IDLE, only that owner SHALL be eligible.
- The other requester SHALL wait, even if the owner's req is low.
- Deasserting lock SHALL release ownership in the same IDLE cycle.
REQ-013 Changes to req, wr, addr or wr_data while in ISSUE or ACK SHALL have no effect on the transaction in flight.

Reset
REQ-014 While reset=0, every output SHALL be 0: grant=0, busy=0, and all strobes, acks and data outputs cleared.
- The state SHALL be IDLE, the lock state SHALL be released, and the last-grant pointer SHALL be 1, so that m0 wins the first contention.
REQ-015 Reset asserted during ISSUE or ACK SHALL abort the transaction with no ack issued.
- Requesters SHALL re-issue the transaction after reset.

Configuration
REQ-016 When ARB_FIXED_PRIO_EN is defined, m0 SHALL always win simultaneous requests and the round-robin pointer SHALL be omitted.
- Lock behaviour SHALL be unchanged under this macro.
- When ARB_FIXED_PRIO_EN is undefined, arbitration SHALL follow REQ-011.

Structure
REQ-017 Package mmio_arb_pkg SHALL hold the state enum typedef (IDLE/ISSUE/ACK) and the default ADDR_W/DATA_W constants.
REQ-018 Sub-module rr_arb2 SHALL hold the two-way winner selection, the last-grant pointer and the lock-ownership logic.
- mmio_bus_arbiter SHALL instantiate rr_arb2 and hold the FSM and command/data registers.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single read: m0 reads addr 0x000C0 while the slot returns 0xDEADBEEF -> mmio_cs=mmio_rd=1 for one cycle at n+1; m0_ack=1 with m0_rd_data=0xDEADBEEF at n+2; m1_ack stays 0.
- Single write: m1 writes 0x00000055 to 0x00080 -> mmio_wr=1, mmio_addr=0x00080, mmio_wr_data=0x55 at n+1; m1_ack at n+2.
- Contention: both req high from reset for 4 transactions -> grant order 0,1,0,1 (with ARB_FIXED_PRIO_EN: 0,0,0,0 until m0 drops req).
- Lock: m1 holds lock for 3 writes while m0 requests -> m0 waits; m0 is granted in the first IDLE after m1_lock falls.
- Reset mid-transaction: reset=0 during ISSUE -> all outputs 0 immediately, no ack; after release, m0 wins a simultaneous request.
- Command change: m0_addr changes during ISSUE -> mmio_addr keeps the value registered in IDLE.
